// File: rtl/ppl_frame_seq.sv
// ppl_frame_seq: frame sequencer owning the pipeline issue slot; PPL_SEQ_STATS_EN adds per-frame stat counters.
module ppl_frame_seq #(
  parameter int H_DISP       = 1280,
  parameter int V_DISP       = 720,
  parameter int MAX_STEPS    = 63,
  parameter int MAX_INFLIGHT = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic [15:0]        p_pos_x,
  input  logic [15:0]        p_pos_y,
  input  logic [15:0]        p_pos_z,
  input  logic signed [15:0] p_angle_x,
  input  logic signed [15:0] p_angle_y,
  input  logic               ret_valid,
  input  logic               ret_hit,
  input  logic [19:0]        ret_pixel_addr,
  input  logic [5:0]         ret_block_cnt,
  output logic [15:0]        f_pos_x,
  output logic [15:0]        f_pos_y,
  output logic [15:0]        f_pos_z,
  output logic signed [15:0] f_angle_x,
  output logic signed [15:0] f_angle_y,
  output logic               issue_valid,
  output logic               issue_new,
  output logic [19:0]        issue_pixel_addr,
  output logic [5:0]         issue_block_cnt,
  output logic               wr_valid,
  output logic [19:0]        wr_pixel_addr,
  output logic [4:0]         inflight,
  output logic               busy,
  output logic               frame_done,
  output logic               overrun
`ifdef PPL_SEQ_STATS_EN
  ,
  output logic [31:0]        stat_cycles,
  output logic [31:0]        stat_steps
`endif
);
  localparam int NPIX = H_DISP * V_DISP;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SCAN  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]  state, nxt;
  logic [19:0] pix_cnt, fresh_addr;
  logic        ret_ok, term, recirc, start, fresh, last;
  // Returns with nothing in flight are stale rays from before a reset.
  always_comb begin
    ret_ok     = ret_valid & (inflight != 5'd0);
    term       = ret_ok & (ret_hit | (ret_block_cnt == 6'(MAX_STEPS)));
    recirc     = ret_ok & ~term;
    start      = frame_start & (state == IDLE);
    fresh      = ((state == SCAN) | start) & ~recirc & (inflight < 5'(MAX_INFLIGHT));
    fresh_addr = start ? 20'd0 : pix_cnt;
    last       = fresh & (fresh_addr == 20'(NPIX - 1));
    nxt        = last ? DRAIN :
                 start ? SCAN :
                 ((state == DRAIN) & (inflight == 5'd0) & ~ret_ok) ? DONE :
                 (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      pix_cnt          <= '0;
      f_pos_x          <= '0;
      f_pos_y          <= '0;
      f_pos_z          <= '0;
      f_angle_x        <= '0;
      f_angle_y        <= '0;
      issue_valid      <= 1'b0;
      issue_new        <= 1'b0;
      issue_pixel_addr <= '0;
      issue_block_cnt  <= '0;
      wr_valid         <= 1'b0;
      wr_pixel_addr    <= '0;
      inflight         <= '0;
      busy             <= 1'b0;
      frame_done       <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      state            <= nxt;
      busy             <= (nxt == SCAN) | (nxt == DRAIN);
      frame_done       <= nxt == DONE;
      overrun          <= overrun | (frame_start & (state != IDLE));
      if (start) begin
        f_pos_x   <= p_pos_x;
        f_pos_y   <= p_pos_y;
        f_pos_z   <= p_pos_z;
        f_angle_x <= p_angle_x;
        f_angle_y <= p_angle_y;
      end
      if (start | fresh) pix_cnt <= fresh_addr + 20'(fresh);
      issue_valid      <= recirc | fresh;
      issue_new        <= fresh;
      issue_pixel_addr <= recirc ? ret_pixel_addr : fresh ? fresh_addr : 20'd0;
      issue_block_cnt  <= recirc ? ret_block_cnt : 6'd0;
      wr_valid         <= term;
      wr_pixel_addr    <= term ? ret_pixel_addr : 20'd0;
      inflight         <= inflight + 5'(fresh) - 5'(term);
    end
  end
`ifdef PPL_SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_cycles <= '0;
      stat_steps  <= '0;
    end else if (start) begin
      stat_cycles <= '0;
      stat_steps  <= '0;
    end else if (busy) begin
      stat_cycles <= stat_cycles + 32'd1;
      stat_steps  <= stat_steps + 32'(recirc);
    end
  end
`endif
endmodule
